// File: rtl/tod_pkg.sv
// Shared constants and display helpers for the time-of-day counter.
package tod_pkg;

  localparam int SEC_MOD_D  = 60;
  localparam int MIN_MOD_D  = 60;
  localparam int HOUR_MOD_D = 24;
  localparam int SEC_W_D    = 6;
  localparam int MIN_W_D    = 6;
  localparam int HOUR_W_D   = 5;

  // Two-digit BCD value; tens never exceeds 7 for any field this block drives.
  typedef struct packed {
    logic [2:0] tens;
    logic [3:0] units;
  } bcd2_t;

  function automatic bcd2_t to_bcd2(input logic [7:0] v);
    bcd2_t r;
    r.tens  = 3'(v / 8'd10);
    r.units = 4'(v % 8'd10);
    return r;
  endfunction

  // 24 h style count to 12 h style display; a zero remainder shows as 'half'.
  function automatic logic [7:0] hour_to_12(input logic [7:0] h, input logic [7:0] half);
    logic [7:0] hm;
    hm = h % half;
    return (hm == 8'd0) ? half : hm;
  endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// Control, load and display bundle of the time-of-day counter.
interface time_of_day_counter_if
  import tod_pkg::*;
#(
  parameter int SEC_W  = SEC_W_D,
  parameter int MIN_W  = MIN_W_D,
  parameter int HOUR_W = HOUR_W_D
);
  logic              en;
  logic              adj_sec;
  logic              adj_min;
  logic              adj_hour;
  logic              updown;
  logic              mode12;
  logic              load;
  logic [SEC_W-1:0]  load_sec;
  logic [MIN_W-1:0]  load_min;
  logic [HOUR_W-1:0] load_hour;
  logic              load_err;
  logic [SEC_W-1:0]  seconds;
  logic [MIN_W-1:0]  minutes;
  logic [HOUR_W-1:0] hours;
  logic [3:0]        seconds_units;
  logic [2:0]        seconds_tens;
  logic [3:0]        minutes_units;
  logic [2:0]        minutes_tens;
  logic [3:0]        hours_units;
  logic [1:0]        hours_tens;
  logic              pm;
  logic              day_tick;

  modport master (
    output en, adj_sec, adj_min, adj_hour, updown, mode12,
           load, load_sec, load_min, load_hour,
    input  load_err, seconds, minutes, hours,
           seconds_units, seconds_tens, minutes_units, minutes_tens,
           hours_units, hours_tens, pm, day_tick
  );

  modport slave (
    input  en, adj_sec, adj_min, adj_hour, updown, mode12,
           load, load_sec, load_min, load_hour,
    output load_err, seconds, minutes, hours,
           seconds_units, seconds_tens, minutes_units, minutes_tens,
           hours_units, hours_tens, pm, day_tick
  );
endinterface

// File: rtl/mod_counter.sv
// One wrapping field counter (0..MOD-1) with load, increment and decrement.
module mod_counter #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] count,
  output logic         wrap_up
);
  localparam logic [W-1:0] MAX = W'(MOD - 1);

  // Carry out: this increment takes the field from MAX back to zero.
  assign wrap_up = inc && (count == MAX);

  // Field state: load wins over stepping; the caller never asserts inc and dec together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (ld) begin
      count <= ld_val;
    end else if (inc) begin
      count <= (count == MAX) ? '0 : count + 1'b1;
    end else if (dec) begin
      count <= (count == '0) ? MAX : count - 1'b1;
    end
  end
endmodule

// File: rtl/time_of_day_counter.sv
// Hours/minutes/seconds timekeeper: run, set and load modes with BCD and 12 h display.
module time_of_day_counter
  import tod_pkg::*;
#(
  parameter int SEC_MOD  = SEC_MOD_D,
  parameter int MIN_MOD  = MIN_MOD_D,
  parameter int HOUR_MOD = HOUR_MOD_D,
  parameter int SEC_W    = SEC_W_D,
  parameter int MIN_W    = MIN_W_D,
  parameter int HOUR_W   = HOUR_W_D
) (
  input logic                  clk,
  input logic                  reset,
  time_of_day_counter_if.slave bus
);
  localparam logic [7:0] HALF = 8'(HOUR_MOD / 2);

  logic              load_ok, load_go, run, adj;
  logic              sec_wrap, min_wrap, hour_wrap;
  logic [SEC_W-1:0]  sec_count;
  logic [MIN_W-1:0]  min_count;
  logic [HOUR_W-1:0] hour_count;
  logic [7:0]        hour_disp;
  bcd2_t             s_bcd, m_bcd, h_bcd;
  logic              unused_hour_tens_msb;

  // Load has priority over the tick, the tick over the adjust strobes.
  assign load_ok = (32'(bus.load_sec) < SEC_MOD) && (32'(bus.load_min) < MIN_MOD)
                && (32'(bus.load_hour) < HOUR_MOD);
  assign load_go = bus.load && load_ok;
  assign run     = bus.en && !bus.load;
  assign adj     = !bus.en && !bus.load;

  mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
    .clk(clk), .reset(reset),
    .inc((run) || (adj && bus.adj_sec && bus.updown)),
    .dec(adj && bus.adj_sec && !bus.updown),
    .ld(load_go), .ld_val(bus.load_sec),
    .count(sec_count), .wrap_up(sec_wrap)
  );

  mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
    .clk(clk), .reset(reset),
    .inc((run && sec_wrap) || (adj && bus.adj_min && bus.updown)),
    .dec(adj && bus.adj_min && !bus.updown),
    .ld(load_go), .ld_val(bus.load_min),
    .count(min_count), .wrap_up(min_wrap)
  );

  mod_counter #(.MOD(HOUR_MOD), .W(HOUR_W)) u_hour (
    .clk(clk), .reset(reset),
    .inc((run && sec_wrap && min_wrap) || (adj && bus.adj_hour && bus.updown)),
    .dec(adj && bus.adj_hour && !bus.updown),
    .ld(load_go), .ld_val(bus.load_hour),
    .count(hour_count), .wrap_up(hour_wrap)
  );

  // Status pulses: rejected load, and full-day wrap in run mode only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.load_err <= 1'b0;
      bus.day_tick <= 1'b0;
    end else begin
      bus.load_err <= bus.load && !load_ok;
      bus.day_tick <= run && sec_wrap && min_wrap && hour_wrap;
    end
  end

  assign bus.seconds = sec_count;
  assign bus.minutes = min_count;
  assign bus.hours   = hour_count;

  // Display path is purely combinational from the registered counts.
  assign hour_disp = bus.mode12 ? hour_to_12(8'(hour_count), HALF) : 8'(hour_count);
  assign s_bcd     = to_bcd2(8'(sec_count));
  assign m_bcd     = to_bcd2(8'(min_count));
  assign h_bcd     = to_bcd2(hour_disp);

  assign bus.seconds_units = s_bcd.units;
  assign bus.seconds_tens  = s_bcd.tens;
  assign bus.minutes_units = m_bcd.units;
  assign bus.minutes_tens  = m_bcd.tens;
  assign bus.hours_units   = h_bcd.units;
  assign bus.hours_tens    = h_bcd.tens[1:0];
  assign unused_hour_tens_msb = h_bcd.tens[2];
  assign bus.pm            = (32'(hour_count) >= (HOUR_MOD / 2));
endmodule

// File: tb/tb_time_of_day_counter.sv
// Randomised and directed bench for time_of_day_counter against a total-seconds model.
module tb_time_of_day_counter;
  import tod_pkg::*;

  localparam int SM = 60, MM = 60, HM = 24;
  localparam int DAY = SM * MM * HM;
  localparam int S_SM = 10, S_MM = 6, S_HM = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  time_of_day_counter_if #(.SEC_W(6), .MIN_W(6), .HOUR_W(5)) bus();
  time_of_day_counter_if #(.SEC_W(4), .MIN_W(3), .HOUR_W(2)) sbus();

  time_of_day_counter #(.SEC_MOD(SM), .MIN_MOD(MM), .HOUR_MOD(HM),
                        .SEC_W(6), .MIN_W(6), .HOUR_W(5))
    dut (.clk(clk), .reset(reset), .bus(bus.slave));

  time_of_day_counter #(.SEC_MOD(S_SM), .MIN_MOD(S_MM), .HOUR_MOD(S_HM),
                        .SEC_W(4), .MIN_W(3), .HOUR_W(2))
    dut_s (.clk(clk), .reset(reset), .bus(sbus.slave));

  int total = 0;
  int bad = 0;
  int ms, mm, mh;
  int m_err, m_day;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = 0; mm = 0; mh = 0; m_err = 0; m_day = 0;
  endtask

  // Reference: time held as seconds-of-day for running, plain modular fields for setting.
  task automatic model_step();
    int t;
    m_err = 0; m_day = 0;
    if (bus.load) begin
      if (int'(bus.load_sec) < SM && int'(bus.load_min) < MM && int'(bus.load_hour) < HM) begin
        ms = int'(bus.load_sec); mm = int'(bus.load_min); mh = int'(bus.load_hour);
      end else begin
        m_err = 1;
      end
    end else if (bus.en) begin
      t = (mh * MM + mm) * SM + ms + 1;
      if (t == DAY) begin
        t = 0;
        m_day = 1;
      end
      ms = t % SM;
      mm = (t / SM) % MM;
      mh = t / (SM * MM);
    end else begin
      if (bus.adj_sec)  ms = bus.updown ? (ms + 1) % SM : (ms + SM - 1) % SM;
      if (bus.adj_min)  mm = bus.updown ? (mm + 1) % MM : (mm + MM - 1) % MM;
      if (bus.adj_hour) mh = bus.updown ? (mh + 1) % HM : (mh + HM - 1) % HM;
    end
  endtask

  task automatic check_all(input string tag);
    int dh;
    dh = mh;
    if (bus.mode12) begin
      dh = mh % (HM / 2);
      if (dh == 0) dh = HM / 2;
    end
    check({tag, ".sec"},  int'(bus.seconds), ms);
    check({tag, ".min"},  int'(bus.minutes), mm);
    check({tag, ".hour"}, int'(bus.hours), mh);
    check({tag, ".su"},   int'(bus.seconds_units), ms % 10);
    check({tag, ".st"},   int'(bus.seconds_tens), ms / 10);
    check({tag, ".mu"},   int'(bus.minutes_units), mm % 10);
    check({tag, ".mt"},   int'(bus.minutes_tens), mm / 10);
    check({tag, ".hu"},   int'(bus.hours_units), dh % 10);
    check({tag, ".ht"},   int'(bus.hours_tens), dh / 10);
    check({tag, ".pm"},   int'(bus.pm), (mh >= HM / 2) ? 1 : 0);
    check({tag, ".err"},  int'(bus.load_err), m_err);
    check({tag, ".day"},  int'(bus.day_tick), m_day);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.en = 0; bus.adj_sec = 0; bus.adj_min = 0; bus.adj_hour = 0;
    bus.updown = 0; bus.load = 0;
    bus.load_sec = '0; bus.load_min = '0; bus.load_hour = '0;
  endtask

  task automatic do_load(input string tag, input int h, input int m, input int s, input logic with_en);
    bus.load = 1; bus.en = with_en;
    bus.load_hour = 5'(h); bus.load_min = 6'(m); bus.load_sec = 6'(s);
    cycle(tag);
    bus.load = 0; bus.en = 0;
  endtask

  initial begin
    int hrs[5];
    int dticks, tick_at;
    idle_inputs();
    bus.mode12 = 0;
    sbus.en = 0; sbus.adj_sec = 0; sbus.adj_min = 0; sbus.adj_hour = 0;
    sbus.updown = 0; sbus.mode12 = 0; sbus.load = 0;
    sbus.load_sec = '0; sbus.load_min = '0; sbus.load_hour = '0;
    model_reset();

    // Power-on reset state
    repeat (2) @(negedge clk);
    check_all("por");
    bus.mode12 = 1; #1;
    check_all("por12");
    bus.mode12 = 0;
    reset = 0;

    // Asynchronous reset in the middle of running at 05:30:17
    @(negedge clk);
    do_load("ld0530", 5, 30, 14, 1'b0);
    bus.en = 1;
    repeat (3) cycle("run0530");
    reset = 1; #2;
    model_reset();
    check_all("arst");
    bus.mode12 = 1; #1;
    check_all("arst12");
    check("arst12.hdigits", int'(bus.hours_tens) * 10 + int'(bus.hours_units), 12);
    bus.mode12 = 0; bus.en = 0;
    @(negedge clk);
    reset = 0;

    // Day rollover
    do_load("ld2359", 23, 59, 58, 1'b0);
    bus.en = 1;
    repeat (3) cycle("wrap");
    check("wrap.end", int'(bus.seconds), 1);
    bus.en = 0;

    // Minute decrement with wrap, hours untouched
    do_load("ld1000", 10, 0, 45, 1'b0);
    bus.adj_min = 1; bus.updown = 0;
    cycle("adjmin");
    check("adjmin.min", int'(bus.minutes), 59);
    bus.adj_min = 0;
    cycle("adjhold");

    // Rejected load, then load colliding with a tick
    do_load("badhour", 24, 0, 0, 1'b0);
    cycle("errclr");
    do_load("ldtick", 12, 0, 0, 1'b1);
    check("ldtick.sec", int'(bus.seconds), 0);

    // 12 h display mapping
    bus.mode12 = 1;
    hrs = '{0, 11, 12, 13, 23};
    foreach (hrs[i]) begin
      do_load("h12", hrs[i], 7, 7, 1'b0);
    end

    // Random mix of run, adjust and load (including out-of-range values)
    for (int n = 0; n < 3000; n++) begin
      bus.load = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.load_hour = 5'(23); bus.load_min = 6'(59); bus.load_sec = 6'($urandom_range(50, 59));
      end else begin
        bus.load_hour = 5'($urandom_range(0, 31));
        bus.load_min  = 6'($urandom_range(0, 63));
        bus.load_sec  = 6'($urandom_range(0, 63));
      end
      bus.en       = ($urandom_range(0, 1) == 1);
      bus.adj_sec  = ($urandom_range(0, 2) == 0);
      bus.adj_min  = ($urandom_range(0, 2) == 0);
      bus.adj_hour = ($urandom_range(0, 2) == 0);
      bus.updown   = ($urandom_range(0, 1) == 1);
      bus.mode12   = ($urandom_range(0, 1) == 1);
      cycle("rnd");
    end
    idle_inputs();

    // Reduced moduli: one full day is 10*6*4 ticks
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    model_reset();
    dticks = 0; tick_at = -1;
    sbus.en = 1;
    for (int n = 1; n <= S_SM * S_MM * S_HM; n++) begin
      @(posedge clk); #1;
      if (sbus.day_tick) begin
        dticks++;
        tick_at = n;
      end
    end
    sbus.en = 0;
    check("small.ticks", dticks, 1);
    check("small.tick_at", tick_at, S_SM * S_MM * S_HM);
    check("small.sec", int'(sbus.seconds), 0);
    check("small.min", int'(sbus.minutes), 0);
    check("small.hour", int'(sbus.hours), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
